// File: rtl/aes_inv_cipher_top.sv
// aes_inv_cipher_top: iterative AES-128 decryption, one inverse round per clock
module aes_inv_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         kdone,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         busy
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254, which also maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                                gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] t;
    logic [127:0] n;
    t = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
    n[127:96] = w[127:96] ^ t;
    n[95:64]  = w[95:64] ^ n[127:96];
    n[63:32]  = w[63:32] ^ n[95:64];
    n[31:0]   = w[31:0] ^ n[63:32];
    return n;
  endfunction
  logic [127:0] kb [0:10];
  logic [127:0] rk, st, sr, sb, ak, mc, rk_cur;
  logic [7:0]   rcon;
  logic [3:0]   kcnt, rcnt;
  logic         kexp;
  assign rk_cur = kb[rcnt];
  assign sr = inv_shift(st);
  for (genvar i = 0; i < 16; i++) begin : g_isb
    assign sb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
  end
  assign ak = sb ^ rk_cur;
  assign mc = inv_mix(ak);
  // forward schedule is captured once, then replayed from kb[10] down to kb[0]
  always_ff @(posedge clk)
    if (kexp) kb[kcnt] <= rk;
  always_ff @(posedge clk)
    if (rst) begin
      kdone    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      kexp     <= 1'b0;
      kcnt     <= 4'd0;
      rcnt     <= 4'd0;
      rcon     <= 8'h00;
      rk       <= '0;
      st       <= '0;
      text_out <= '0;
    end else if (kld) begin
      kdone <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      kexp  <= 1'b1;
      kcnt  <= 4'd0;
      rcnt  <= 4'd0;
      rk    <= key;
      rcon  <= 8'h01;
    end else begin
      done <= 1'b0;
      if (kexp) begin
        rk    <= key_next(rk, rcon);
        rcon  <= xtime(rcon);
        kcnt  <= kcnt + 4'd1;
        kexp  <= kcnt != 4'd10;
        kdone <= kcnt == 4'd10;
      end
      if (ld && kdone) begin
        st   <= text_in;
        busy <= 1'b1;
        rcnt <= 4'd10;
      end else if (busy) begin
        st   <= rcnt == 4'd10 ? st ^ rk_cur : mc;
        rcnt <= rcnt == 4'd0 ? rcnt : rcnt - 4'd1;
        done <= rcnt == 4'd0;
        busy <= rcnt != 4'd0;
        if (rcnt == 4'd0) text_out <= ak;
      end
    end
endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// tb_aes_inv_cipher_top: randomized bench with a transaction-level AES decryption model
module tb_aes_inv_cipher_top;
  logic clk = 1'b0, rst = 1'b1, kld = 1'b0, ld = 1'b0;
  logic [127:0] key = '0, text_in = '0;
  logic [127:0] text_out;
  logic kdone, done, busy;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int kage = -1, bage = -1;
  logic [127:0] mkey = '0, mct = '0, exp_out = '0;
  logic [7:0] sbt [256];
  logic [7:0] isbt [256];

  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KB10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_inv_cipher_top dut (.clk(clk), .rst(rst), .kld(kld), .key(key), .kdone(kdone),
                          .ld(ld), .text_in(text_in), .text_out(text_out), .done(done), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbt[x] = s;
      isbt[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40+i/4][31-8*(i%4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = isbt[s[4*((c-r+4)%4)+r]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rd+i/4][31-8*(i%4) -: 8];
      if (rd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // model: key age and block age in cycles since their accepted load edge
  initial forever begin
    bit kd;
    @(posedge clk);
    if (rst) begin
      kage = -1; bage = -1; exp_out = '0;
    end else if (kld) begin
      kage = 0; mkey = key; bage = -1;
    end else begin
      kd = kage >= 11;
      if (kage >= 0 && kage < 11) kage++;
      if (ld && kd) begin
        bage = 0; mct = text_in;
      end else if (bage >= 0 && bage < 11) begin
        bage++;
        if (bage == 11) exp_out = aes_dec(mkey, mct);
      end else bage = -1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("kdone", 128'(kdone), 128'(kage >= 11));
      chk("busy", 128'(busy), 128'(bage >= 0 && bage <= 10));
      chk("done", 128'(done), 128'(bage == 11));
      chk("text_out", text_out, exp_out);
    end
  end

  task automatic load_key(input logic [127:0] k, output int cyc);
    key = k; kld = 1'b1;
    @(negedge clk);
    kld = 1'b0; cyc = 0;
    while (!kdone && cyc < 30) begin @(negedge clk); cyc++; end
  endtask

  task automatic run_blk(input logic [127:0] ct, output int cyc);
    text_in = ct; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; cyc = 0;
    while (!done && cyc < 30) begin @(negedge clk); cyc++; end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int cyc, n;
    logic [127:0] k, ct;
    build_tables();
    chk("model_fips_b", aes_dec(K_B, CT_B), PT_B);
    chk("model_fips_c1", aes_dec(K_C1, CT_C1), PT_C1);
    chk("model_zero_key", aes_dec('0, CT_Z), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_text_out", text_out, '0);
    chk("rst_kdone", 128'(kdone), '0);
    load_key(K_B, cyc);
    chk("kdone_latency", cyc, 11);
    chk("kb10", dut.kb[10], KB10);
    run_blk(CT_B, cyc);
    chk("done_latency", cyc, 11);
    chk("pt_fips_b", text_out, PT_B);
    @(negedge clk);
    chk("done_width", 128'(done), '0);
    load_key(K_C1, cyc);
    run_blk(CT_C1, cyc);
    chk("pt_fips_c1", text_out, PT_C1);
    ct = r128();
    text_in = ct; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; cyc = 0;
    while (!done && cyc < 30) begin
      chk("b2b_hold", text_out, PT_C1);
      @(negedge clk); cyc++;
    end
    chk("b2b_latency", cyc, 11);
    chk("b2b_pt", text_out, aes_dec(K_C1, ct));
    load_key('0, cyc);
    run_blk(CT_Z, cyc);
    chk("pt_zero_key", text_out, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; text_in = r128(); ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; n = 0;
    repeat (20) begin @(negedge clk); n += int'(done); end
    chk("ld_without_key", n, 0);
    k = r128();
    load_key(k, cyc);
    text_in = r128(); ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (3) @(negedge clk);
    kld = 1'b1;
    @(negedge clk);
    kld = 1'b0;
    chk("kld_abort_busy", 128'(busy), '0);
    chk("kld_abort_kdone", 128'(kdone), '0);
    n = 0;
    repeat (20) begin @(negedge clk); n += int'(done); end
    chk("kld_abort_no_done", n, 0);
    key = r128(); text_in = r128(); kld = 1'b1; ld = 1'b1;
    @(negedge clk);
    kld = 1'b0; ld = 1'b0;
    chk("kld_ld_busy", 128'(busy), '0);
    chk("kld_ld_kdone", 128'(kdone), '0);
    n = 0;
    repeat (20) begin @(negedge clk); n += int'(done); end
    chk("kld_ld_no_done", n, 0);
    k = r128();
    load_key(k, cyc);
    ct = r128();
    run_blk(ct, cyc);
    chk("pre_rst_pt", text_out, aes_dec(k, ct));
    text_in = r128(); ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_done", 128'(done), '0);
    chk("mid_rst_busy", 128'(busy), '0);
    chk("mid_rst_kdone", 128'(kdone), '0);
    chk("mid_rst_text_out", text_out, '0);
    load_key(k, cyc);
    ct = r128();
    run_blk(ct, cyc);
    chk("post_rst_pt", text_out, aes_dec(k, ct));
    key = r128(); kld = 1'b1;
    @(negedge clk);
    kld = 1'b0; n = 0;
    for (int i = 0; i < 2500; i++) begin
      rst = $urandom_range(0, 599) == 0;
      kld = $urandom_range(0, 119) == 0;
      ld = $urandom_range(0, 13) == 0;
      key = r128();
      text_in = r128();
      @(negedge clk);
      n += int'(done);
    end
    rst = 1'b0; kld = 1'b0; ld = 1'b0;
    chk("random_dones_seen", 128'(n > 10), 128'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
